// File: rtl/tlc_chain_readback_if.sv
// RAM write port that carries deserialised chain words to the readback memory.
interface tlc_chain_readback_if #(
    parameter int ADDR_W = 8
);
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [47:0]       wrData;

    modport master (output wrEn, wrAddr, wrData);
    modport slave  (input  wrEn, wrAddr, wrData);
endinterface

// File: rtl/tlc_chain_readback.sv
// Receive end of the TLC5955 daisy chain: checks frame framing on the SOUT loopback
// and deserialises every 48-bit word of every lane onto a RAM write port.
module tlc_chain_readback #(
    parameter int NUM_SHIFT_CHANNEL = 4,
    parameter int WORDS_PER_SEG     = 16,
    parameter int SEGMENTS          = 2
) (
    input  logic                           spiClk,
    input  logic                           nReset,
    input  logic                           enable,
    input  logic                           SCLK_in,
    input  logic                           LAT_in,
    input  logic [2*NUM_SHIFT_CHANNEL-1:0] SIN,
    tlc_chain_readback_if.master           wr,
    output logic                           busy,
    output logic                           frameDone,
    output logic                           frameErr,
    output logic [1:0]                     errCode
);
    localparam int L      = 2 * NUM_SHIFT_CHANNEL;
    localparam int LANE_W = $clog2(L);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(L - 1);
    localparam logic [4:0]        LAST_WORD = 5'(WORDS_PER_SEG - 1);
    localparam logic [4:0]        LAST_SEG  = 5'(SEGMENTS - 1);
    localparam logic [4:0]        SEG_WORDS = 5'(WORDS_PER_SEG);

    typedef enum logic [2:0] {IDLE, SEL, DATA, DRAIN, WAIT_LAT, RESYNC} state_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_SEL, ERR_SHORT, ERR_EXTRA} err_t;

    state_t            state, state_next;
    err_t              err_kind;
    logic              sclk_q, lat_q, sclk_rise, lat_rise;
    logic [4:0]        seg, word, word_idx;
    logic [5:0]        bit_cnt;
    logic [LANE_W-1:0] lane;
    logic [47:0]       sreg [L];
    logic [47:0]       hold [L];
    logic              start, sel_ok, shift, capture, drain_step;
    logic              wr_en, write, err_fire, done_fire;

    assign sclk_rise = SCLK_in & ~sclk_q;
    assign lat_rise  = LAT_in & ~lat_q;
    assign word_idx  = seg * SEG_WORDS + word;
    assign busy      = (state != IDLE) && (state != RESYNC);

    always_ff @(posedge spiClk) begin
        if (!nReset) state <= IDLE;
        else         state <= state_next;
    end

    // LAT is evaluated before SCLK everywhere it matters, so a coincident rise reports SHORT.
    always_comb begin
        state_next = state;
        err_kind   = ERR_NONE;
        err_fire   = 1'b0;
        done_fire  = 1'b0;
        start      = 1'b0;
        sel_ok     = 1'b0;
        shift      = 1'b0;
        capture    = 1'b0;
        drain_step = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (sclk_rise && enable) begin
                    start = 1'b1;
                    if (|SIN) begin
                        err_fire = 1'b1;
                        err_kind = ERR_SEL;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            SEL: begin
                if (lat_rise) begin
                    err_fire = 1'b1;
                    err_kind = ERR_SHORT;
                end else if (sclk_rise) begin
                    if (|SIN) begin
                        err_fire = 1'b1;
                        err_kind = ERR_SEL;
                    end else begin
                        sel_ok     = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (lat_rise) begin
                    err_fire = 1'b1;
                    err_kind = ERR_SHORT;
                end else if (sclk_rise) begin
                    shift = 1'b1;
                    if (bit_cnt == 6'd47) begin
                        capture    = 1'b1;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (lat_rise) begin
                    err_fire = 1'b1;
                    err_kind = ERR_SHORT;
                end else if (sclk_rise) begin
                    err_fire = 1'b1;
                    err_kind = ERR_EXTRA;
                end else begin
                    wr_en      = 1'b1;
                    drain_step = 1'b1;
                    if (lane == LAST_LANE) begin
                        if (word != LAST_WORD)    state_next = DATA;
                        else if (seg != LAST_SEG) state_next = SEL;
                        else                      state_next = WAIT_LAT;
                    end
                end
            end
            WAIT_LAT: begin
                if (lat_rise) begin
                    done_fire  = 1'b1;
                    state_next = IDLE;
                end else if (sclk_rise) begin
                    err_fire = 1'b1;
                    err_kind = ERR_EXTRA;
                end
            end
            RESYNC: begin
                if (lat_rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (err_fire) state_next = RESYNC;
    end

    always_ff @(posedge spiClk) begin
        if (!nReset) begin
            sclk_q    <= 1'b0;
            lat_q     <= 1'b0;
            seg       <= '0;
            word      <= '0;
            bit_cnt   <= '0;
            lane      <= '0;
            frameDone <= 1'b0;
            frameErr  <= 1'b0;
            errCode   <= ERR_NONE;
        end else begin
            sclk_q    <= SCLK_in;
            lat_q     <= LAT_in;
            frameDone <= done_fire;
            frameErr  <= err_fire;
            if (err_fire)   errCode <= err_kind;
            else if (start) errCode <= ERR_NONE;
            if (start) begin
                seg  <= '0;
                word <= '0;
            end
            if (start || sel_ok) bit_cnt <= '0;
            if (shift) bit_cnt <= capture ? 6'd0 : bit_cnt + 6'd1;
            if (capture) lane <= '0;
            if (drain_step) begin
                lane <= lane + 1'b1;
                if (lane == LAST_LANE) begin
                    lane <= '0;
                    if (word != LAST_WORD) begin
                        word <= word + 5'd1;
                    end else if (seg != LAST_SEG) begin
                        seg  <= seg + 5'd1;
                        word <= '0;
                    end
                end
            end
        end
    end

    // Shift and hold registers are fully rewritten before any read, so they need no reset.
    always_ff @(posedge spiClk) begin
        if (shift) begin
            for (int i = 0; i < L; i++) begin
                sreg[i] <= {sreg[i][46:0], SIN[i]};
                if (capture) hold[i] <= {sreg[i][46:0], SIN[i]};
            end
        end
    end

    assign write      = wr_en & nReset;
    assign wr.wrEn    = write;
    assign wr.wrAddr  = write ? {lane, word_idx} : '0;
    assign wr.wrData  = write ? hold[lane] : '0;
endmodule
